// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered long-latency results
// into the single register file write port, and tracks pending registers.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ll_valid,
    output logic            ll_ready,
    input  logic [4:0]      ll_rd,
    input  logic [XLEN-1:0] ll_data,
    input  logic            issue_valid,
    input  logic            issue_long,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    input  logic [4:0]      chk_rd,
    output logic            hazard,
    output logic [31:0]     pending,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CW-1:0]   count;

    logic            push;
    logic            pop;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;
    logic            set_en;
    logic [31:0]     pend_nxt;

    assign ll_ready  = (count != FULL);
    assign push      = ll_valid && ll_ready;
    assign pop       = !alu_valid && (count != '0);
    assign head_rd   = rd_q[head];
    assign head_data = data_q[head];
    assign set_en    = issue_valid && issue_long && (issue_rd != 5'd0);

    assign hazard = ((chk_rs1 != 5'd0) && pending[chk_rs1]) ||
                    ((chk_rs2 != 5'd0) && pending[chk_rs2]) ||
                    ((chk_rd  != 5'd0) && pending[chk_rd]);

    // Clear is applied before set so a same-cycle issue keeps the bit.
    always_comb begin
        pend_nxt = pending;
        if (pop && (head_rd != 5'd0))
            pend_nxt[head_rd] = 1'b0;
        if (set_en)
            pend_nxt[issue_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail]   <= ll_rd;
            data_q[tail] <= ll_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            pending <= '0;
            rf_we   <= 1'b0;
            rf_wa   <= '0;
            rf_wd   <= '0;
        end else begin
            pending <= pend_nxt;
            if (push)
                tail <= tail + AW'(1);
            if (pop)
                head <= head + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (alu_valid) begin
                rf_we <= (alu_rd != 5'd0);
                rf_wa <= alu_rd;
                rf_wd <= alu_data;
            end else if (pop) begin
                rf_we <= (head_rd != 5'd0);
                rf_wa <= head_rd;
                rf_wd <= head_data;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ll_valid;
    logic            ll_ready;
    logic [4:0]      ll_rd;
    logic [XLEN-1:0] ll_data;
    logic            issue_valid;
    logic            issue_long;
    logic [4:0]      issue_rd;
    logic [4:0]      chk_rs1;
    logic [4:0]      chk_rs2;
    logic [4:0]      chk_rd;
    logic            hazard;
    logic [31:0]     pending;
    logic            rf_we;
    logic [4:0]      rf_wa;
    logic [XLEN-1:0] rf_wd;

    wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd),
        .ll_data(ll_data),
        .issue_valid(issue_valid), .issue_long(issue_long),
        .issue_rd(issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .hazard(hazard), .pending(pending),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pend;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_hazard();
        logic h;
        h = 1'b0;
        if (chk_rs1 != 0 && m_pend[chk_rs1]) h = 1'b1;
        if (chk_rs2 != 0 && m_pend[chk_rs2]) h = 1'b1;
        if (chk_rd  != 0 && m_pend[chk_rd])  h = 1'b1;
        return h;
    endfunction

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ll_valid = 0; ll_rd = 0; ll_data = 0;
        issue_valid = 0; issue_long = 0; issue_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
    endtask

    // Advance one clock: update the model from the current inputs, then
    // compare every output 1ns after the edge.
    task automatic step();
        ent_t e;
        logic push;
        push = ll_valid && (q.size() != DEPTH);
        if (alu_valid) begin
            m_we = (alu_rd != 0); m_wa = alu_rd; m_wd = alu_data;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            m_we = (e.rd != 0); m_wa = e.rd; m_wd = e.data;
            if (e.rd != 0) m_pend[e.rd] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (push) begin
            e.rd = ll_rd; e.data = ll_data;
            q.push_back(e);
        end
        if (issue_valid && issue_long && issue_rd != 0)
            m_pend[issue_rd] = 1'b1;
        @(posedge clk);
        #1;
        chk("rf_we", 64'(rf_we), 64'(m_we));
        chk("rf_wa", 64'(rf_wa), 64'(m_wa));
        chk("rf_wd", 64'(rf_wd), 64'(m_wd));
        chk("pending", 64'(pending), 64'(m_pend));
        chk("ll_ready", 64'(ll_ready), 64'(q.size() != DEPTH));
        chk("hazard", 64'(hazard), 64'(m_hazard()));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_ready", 64'(ll_ready), 64'd1);
        q.delete();
        m_pend = 0; m_we = 0; m_wa = 0; m_wd = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wa", 64'(rf_wa), 64'd0);
        chk("rst_wd", 64'(rf_wd), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int nxt;
        rst_n = 1'b0;
        idle_inputs();
        #2;
        do_reset();
        repeat (5) step();

        // ALU path
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        step();
        chk("alu_we", 64'(rf_we), 64'd1);
        chk("alu_wa", 64'(rf_wa), 64'd5);
        chk("alu_wd", 64'(rf_wd), 64'hDEADBEEF);
        idle_inputs();
        step();
        chk("alu_we_drop", 64'(rf_we), 64'd0);

        // Long-latency path with scoreboard
        issue_valid = 1; issue_long = 1; issue_rd = 7;
        step();
        idle_inputs();
        chk_rs1 = 7;
        #1;
        chk("pend7_set", 64'(pending[7]), 64'd1);
        chk("haz_rs1", 64'(hazard), 64'd1);
        step();
        ll_valid = 1; ll_rd = 7; ll_data = 32'h1234;
        step();
        ll_valid = 0;
        step();
        chk("ll_we", 64'(rf_we), 64'd1);
        chk("ll_wa", 64'(rf_wa), 64'd7);
        chk("ll_wd", 64'(rf_wd), 64'h1234);
        chk("pend7_clr", 64'(pending[7]), 64'd0);
        chk("haz_clr", 64'(hazard), 64'd0);
        idle_inputs();
        step();

        // Back-pressure while the ALU occupies the port
        nxt = 1;
        alu_valid = 1; alu_rd = 10;
        for (int c = 0; c < 8; c++) begin
            alu_data = $urandom;
            ll_valid = (nxt <= 6); ll_rd = 5'(nxt); ll_data = 32'(nxt * 16);
            if (ll_ready && nxt <= 6) nxt++;
            step();
        end
        chk("bp_ready", 64'(ll_ready), 64'd0);
        chk("bp_pushed", 64'(nxt), 64'd5);
        alu_valid = 0;
        for (int k = 1; k <= 6; k++) begin
            ll_valid = (nxt <= 6); ll_rd = 5'(nxt); ll_data = 32'(nxt * 16);
            if (ll_ready && nxt <= 6) nxt++;
            step();
            chk("bp_order_we", 64'(rf_we), 64'd1);
            chk("bp_order_wa", 64'(rf_wa), 64'(k));
        end
        idle_inputs();
        step();
        chk("bp_idle", 64'(rf_we), 64'd0);

        // x0 filtering
        alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
        step();
        chk("x0_alu", 64'(rf_we), 64'd0);
        idle_inputs();
        ll_valid = 1; ll_rd = 0; ll_data = 32'h66;
        step();
        idle_inputs();
        step();
        chk("x0_ll", 64'(rf_we), 64'd0);
        chk("x0_pend", 64'(pending), 64'd0);
        chk("x0_drained", 64'(q.size()), 64'd0);

        // Set/clear collision on rd 9
        issue_valid = 1; issue_long = 1; issue_rd = 9;
        step();
        idle_inputs();
        ll_valid = 1; ll_rd = 9; ll_data = 32'h99;
        step();
        idle_inputs();
        issue_valid = 1; issue_long = 1; issue_rd = 9;
        step();
        chk("coll_we", 64'(rf_we), 64'd1);
        chk("coll_pend9", 64'(pending[9]), 64'd1);
        idle_inputs();
        step();

        // Mid-operation reset with buffered entries
        issue_valid = 1; issue_long = 1; issue_rd = 3;
        step();
        issue_rd = 4;
        step();
        issue_valid = 0;
        alu_valid = 1; alu_rd = 12;
        for (int k = 0; k < 3; k++) begin
            ll_valid = 1; ll_rd = 5'(3 + k); ll_data = 32'(k);
            step();
        end
        ll_valid = 0;
        chk("mid_entries", 64'(q.size()), 64'd3);
        #2;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_rst_we", 64'(rf_we), 64'd0);
        end

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            alu_valid   = ($urandom_range(0, 3) == 0);
            alu_rd      = 5'($urandom);
            alu_data    = $urandom;
            ll_valid    = ($urandom_range(0, 1) == 1);
            ll_rd       = 5'($urandom_range(0, 7));
            ll_data     = $urandom;
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_long  = ($urandom_range(0, 1) == 1);
            issue_rd    = 5'($urandom_range(0, 7));
            chk_rs1     = 5'($urandom_range(0, 7));
            chk_rs2     = 5'($urandom_range(0, 7));
            chk_rd      = 5'($urandom_range(0, 7));
            step();
        end
        idle_inputs();
        repeat (DEPTH + 2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the RISC-V core. It merges single-cycle ALU results with buffered long-latency results (load, mul/div) into the register file's single write port. It also keeps a per-register pending scoreboard so the issue stage can detect RAW and WAW hazards. It sits between the execute/memory units and the register file write port (`we`/`wa`/`wd`).

## Interface
- `DEPTH`, 4: long-latency result FIFO entries (power of two, ≥2)
- `XLEN`, 32: data width
- `clk`  in  1  core clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU result present this cycle; has no ready and is always accepted
- `alu_rd`  in  5  ALU destination register
- `alu_data`  in  XLEN  ALU result
- `ll_valid`  in  1  long-latency result offered
- `ll_ready`  out  1  FIFO can accept; equals `count != DEPTH`
- `ll_rd`  in  5  long-latency destination
- `ll_data`  in  XLEN  long-latency result
- `issue_valid`  in  1  instruction issuing this cycle
- `issue_long`  in  1  issuing instruction writes back through the long-latency path
- `issue_rd`  in  5  issuing instruction destination
- `chk_rs1`, `chk_rs2`, `chk_rd`  in  5 each  registers of the candidate instruction
- `hazard`  out  1  combinational: any nonzero `chk_*` has its pending bit set
- `pending`  out  32  scoreboard, bit 0 always 0
- `rf_we`  out  1  register file write enable (registered)
- `rf_wa`  out  5  register file write address (registered)
- `rf_wd`  out  XLEN  register file write data (registered)

## Operation
- **FIFO.** A push occurs when `ll_valid && ll_ready`. Entries hold {rd, data}. Head and tail pointers wrap modulo DEPTH, and `count` ranges 0..DEPTH.
  - Push and pop in the same cycle: count is unchanged.
  - There is no push when full, even if a pop happens that cycle. No fall-through.
- **Arbitration**, evaluated each cycle:
  - `alu_valid=1`: the ALU wins. Next-cycle outputs are rf_we=(alu_rd!=0), rf_wa=alu_rd, rf_wd=alu_data.
  - Otherwise, if the FIFO is non-empty: pop the head. Next-cycle outputs are rf_we=(head.rd!=0), rf_wa=head.rd, rf_wd=head.data.
  - Otherwise: rf_we=0. rf_wa and rf_wd hold their previous values.
- **x0 handling.** Results targeting x0 are accepted and popped normally but never produce rf_we=1.
- **Starvation.** While alu_valid is held high, the FIFO does not drain. It fills, and `ll_ready` deasserts to back-pressure the unit. No data is lost.
- **Scoreboard set.** When `issue_valid && issue_long && issue_rd!=0`, `pending[issue_rd]` is set on the next edge.
- **Scoreboard clear.** A FIFO pop with head.rd!=0 clears `pending[head.rd]` on the same edge the pop registers.
- **Simultaneous set and clear** of the same rd: set wins, so the bit stays 1.
- **WAW.** The issue stage must not issue any instruction with `hazard=1`. This guarantees no ALU write targets a pending register. The arbiter does not check for this.

## Timing
- **Reset** (asynchronous on rst_n low, held until release): rf_we=0, rf_wa=0, rf_wd=0, pending=0, FIFO empty (count=0, pointers=0), ll_ready=1.
  - Reset mid-operation discards all FIFO entries and pending bits immediately.
- **ALU latency.** alu_valid in cycle N gives rf_we=1 in cycle N+1. The register file updates at the end of N+1.
- **Long-latency latency.** A push in cycle N with an empty FIFO and alu_valid=0 in N+1 gives a pop in N+1 and rf_we=1 in N+2. Each cycle of ALU occupancy adds one cycle.
- **Pending clear** becomes visible in the same cycle rf_we=1 for that write (N+2 in the unloaded case).
- **hazard** is purely combinational from the `pending` register and the `chk_*` inputs. There is no same-cycle bypass of issue sets.
- **Throughput.** At most one register write per cycle. The FIFO sustains one push and one pop per cycle.

## Test plan
1. **Reset and ALU path.** Hold rst_n=0 for 3 cycles, then release. Drive alu_valid with rd=5, data=0xDEADBEEF in cycle 10 -> rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF in cycle 11, and rf_we=0 in cycle 12.
2. **Long-latency path with scoreboard.** Issue long with rd=7 in cycle 5 -> pending[7]=1 from cycle 6, and hazard=1 for chk_rs1=7. Push rd=7, data=0x1234 in cycle 9 -> rf_we=1, rf_wa=7 in cycle 11, and pending[7]=0 in cycle 11.
3. **Back-pressure.** With DEPTH=4, hold alu_valid=1 for 8 cycles while ll_valid=1 with rd=1..6 -> ll_ready=0 after 4 pushes. After alu_valid drops, rd 1,2,3,4,5,6 are written in order on consecutive cycles.
4. **x0 filtering.** ALU rd=0 and a long-latency result with rd=0 -> no rf_we pulse. The FIFO still pops, and pending is unchanged.
5. **Set/clear collision.** A pop for rd=9 and an issue-long of rd=9 in the same cycle -> pending[9] remains 1.
6. **Mid-operation reset.** With 3 FIFO entries and pending bits set, assert rst_n=0 asynchronously -> rf_we=0, pending=0, ll_ready=1 before the next clock edge. No writes occur after release.
